// File: rtl/tw_pkg.sv
// Shared constants and types for the twiddle-factor load path.
package tw_pkg;

    localparam int unsigned TW_P_WIDTH = 128;
    localparam int unsigned TW_HDW     = 64;
    localparam int unsigned TW_DEPTH   = 4;
    localparam int unsigned TW_IDX_W   = 2;

    // Write codes understood by the ROM stage-0 buffer
    localparam logic [1:0] ROM_W_IDLE = 2'd0;
    localparam logic [1:0] ROM_W_HI   = 2'd1;
    localparam logic [1:0] ROM_W_LO   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SEND_HI = 3'd2,
        ST_SEND_LO = 3'd3,
        ST_DONE    = 3'd4
    } tw_state_e;

endpackage

// File: rtl/tw_word_buf.sv
// DEPTH x P_WIDTH word store with one write port and a half-selecting read port.
module tw_word_buf
    import tw_pkg::*;
#(
    parameter int unsigned P_WIDTH = TW_P_WIDTH,
    parameter int unsigned HALF_W  = TW_HDW,
    parameter int unsigned DEPTH   = TW_DEPTH,
    parameter int unsigned IDX_W   = TW_IDX_W
) (
    input  logic               CLK,
    input  logic               we,
    input  logic [IDX_W-1:0]   waddr,
    input  logic [P_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]   raddr,
    input  logic               rd_hi,
    output logic [HALF_W-1:0]  rdata_c
);

    logic [P_WIDTH-1:0] mem_q [DEPTH];
    logic [P_WIDTH-1:0] word_c;

    // Word storage; contents are deliberately not reset
    always_ff @(posedge CLK) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read the addressed word and pick the requested half
    always_comb begin
        word_c  = mem_q[raddr];
        rdata_c = rd_hi ? word_c[P_WIDTH-1:HALF_W] : word_c[HALF_W-1:0];
    end

endmodule

// File: rtl/tw_horizontal_tx.sv
// Collects DEPTH twiddle words and streams them to the ROM as upper-half then lower-half beats.
module tw_horizontal_tx
    import tw_pkg::*;
#(
    parameter int unsigned P_WIDTH       = TW_P_WIDTH,
    parameter int unsigned horizontal_DW = TW_HDW,
    parameter int unsigned DEPTH         = TW_DEPTH,
    parameter int unsigned IDX_W         = TW_IDX_W
) (
    input  logic                     CLK,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [P_WIDTH-1:0]       in_data,
    output logic                     in_ready,
    output logic [horizontal_DW-1:0] horizontal_tf_out,
    output logic [1:0]               ROM_w,
    output logic                     busy,
    output logic                     done
);

    tw_state_e                state_q, state_d;
    logic [IDX_W-1:0]         wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]         rd_idx_q, rd_idx_d;
    logic [horizontal_DW-1:0] tf_q, tf_d;
    logic [1:0]               rom_w_q, rom_w_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;
    logic                     in_ready_q, in_ready_d;

    logic                     buf_we_c;
    logic [IDX_W-1:0]         raddr_c;
    logic                     rd_hi_c;
    logic [horizontal_DW-1:0] rd_data_c;

    tw_word_buf #(
        .P_WIDTH (P_WIDTH),
        .HALF_W  (horizontal_DW),
        .DEPTH   (DEPTH),
        .IDX_W   (IDX_W)
    ) u_buf (
        .CLK     (CLK),
        .we      (buf_we_c),
        .waddr   (wr_idx_q),
        .wdata   (in_data),
        .raddr   (raddr_c),
        .rd_hi   (rd_hi_c),
        .rdata_c (rd_data_c)
    );

    // Read select: word 0 upper half on the final load edge, otherwise rd_idx; a wrapped
    // rd_idx in SEND_HI means the upper pass is complete and the lower pass starts
    always_comb begin
        raddr_c = (state_q == ST_LOAD) ? '0 : rd_idx_q;
        rd_hi_c = (state_q == ST_LOAD) ||
                  ((state_q == ST_SEND_HI) && (rd_idx_q != '0));
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        tf_d       = tf_q;
        rom_w_d    = ROM_W_IDLE;
        done_d     = 1'b0;
        buf_we_c   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    wr_idx_d = '0;
                end
            end
            ST_LOAD: begin
                if (in_valid && in_ready_q) begin
                    buf_we_c = 1'b1;
                    wr_idx_d = wr_idx_q + IDX_W'(1);
                    if (wr_idx_q == IDX_W'(DEPTH - 1)) begin
                        state_d  = ST_SEND_HI;
                        tf_d     = rd_data_c;
                        rom_w_d  = ROM_W_HI;
                        rd_idx_d = IDX_W'(1);
                    end
                end
            end
            ST_SEND_HI: begin
                tf_d = rd_data_c;
                if (rd_idx_q == '0) begin
                    state_d  = ST_SEND_LO;
                    rom_w_d  = ROM_W_LO;
                    rd_idx_d = IDX_W'(1);
                end else begin
                    rom_w_d  = ROM_W_HI;
                    rd_idx_d = rd_idx_q + IDX_W'(1);
                end
            end
            ST_SEND_LO: begin
                if (rd_idx_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    tf_d     = rd_data_c;
                    rom_w_d  = ROM_W_LO;
                    rd_idx_d = rd_idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d     = (state_d == ST_LOAD) || (state_d == ST_SEND_HI) ||
                     (state_d == ST_SEND_LO);
        in_ready_d = (state_d == ST_LOAD);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            tf_q       <= '0;
            rom_w_q    <= ROM_W_IDLE;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            tf_q       <= tf_d;
            rom_w_q    <= rom_w_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready          = in_ready_q;
    assign horizontal_tf_out = tf_q;
    assign ROM_w             = rom_w_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

// File: tb/tb_tw_horizontal_tx.sv
// Randomized self-checking bench for tw_horizontal_tx with a transaction-level reference model.
module tb_tw_horizontal_tx;

    localparam int unsigned PW    = 128;
    localparam int unsigned HW    = 64;
    localparam int unsigned DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic [PW-1:0] in_data;
    logic          in_ready;
    logic [HW-1:0] tf_out;
    logic [1:0]    rom_w;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    tw_horizontal_tx dut (
        .CLK               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .horizontal_tf_out (tf_out),
        .ROM_w             (rom_w),
        .busy              (busy),
        .done              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic comparison: bumps the counters and reports any difference
    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // mode: 0 idle, 1 collecting words, 2 streaming beat k, 3 done cycle
    int            m_mode = 0;
    int            m_k    = 0;
    logic [PW-1:0] m_q[$];
    logic [PW-1:0] m_word;
    logic [HW-1:0] e_tf   = '0;
    logic [1:0]    e_w    = '0;
    logic          e_done = 1'b0;
    logic          e_busy = 1'b0;
    logic          e_rdy  = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0;
            m_q.delete();
            e_tf   = '0;
            e_w    = 2'd0;
            e_done = 1'b0;
        end else begin
            case (m_mode)
                0: if (start) begin m_mode = 1; m_q.delete(); end
                1: if (in_valid) begin
                       m_q.push_back(in_data);
                       if (m_q.size() == DEPTH) begin m_mode = 2; m_k = 0; end
                   end
                2: begin m_k++; if (m_k == 2 * DEPTH) m_mode = 3; end
                default: m_mode = 0;
            endcase
            e_done = (m_mode == 3);
            if (m_mode == 2) begin
                if (m_k < DEPTH) begin
                    m_word = m_q[m_k];
                    e_tf   = m_word[PW-1:HW];
                    e_w    = 2'd1;
                end else begin
                    m_word = m_q[m_k - DEPTH];
                    e_tf   = m_word[HW-1:0];
                    e_w    = 2'd2;
                end
            end else begin
                e_w = 2'd0;
            end
        end
        e_busy = (m_mode == 1) || (m_mode == 2);
        e_rdy  = (m_mode == 1);
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rom_w",    PW'(rom_w),    PW'(e_w));
            chk("done",     PW'(done),     PW'(e_done));
            chk("busy",     PW'(busy),     PW'(e_busy));
            chk("in_ready", PW'(in_ready), PW'(e_rdy));
            if (e_w != 2'd0) chk("tf_out", PW'(tf_out), PW'(e_tf));
        end
    end

    // ---------------- receiver: ROM stage-0 buffer behaviour ----------------
    logic [PW-1:0] rx_mem [DEPTH];
    int            rx_slot = 0;

    always @(negedge clk) begin
        if (rom_w == 2'd0) begin
            rx_slot = 0;
        end else begin
            if (rom_w == 2'd1) rx_mem[rx_slot][PW-1:HW] = tf_out;
            else               rx_mem[rx_slot][HW-1:0]  = tf_out;
            rx_slot = (rx_slot + 1) % DEPTH;
        end
    end

    // ---------------- stimulus ----------------
    logic [PW-1:0] cur_w   [DEPTH];
    logic [HW-1:0] lit_beat[2*DEPTH];

    // throttle: 0 back-to-back, 1 strict alternate, 2 random gaps
    task automatic run_xfer(input int throttle, input bit lit, input bit noise, input int abort_beat);
        int  i;
        int  c1;
        bit  seen;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        i = 0;
        while (i < DEPTH) begin
            if ((throttle == 1 && i > 0) || (throttle == 2 && $urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom, $urandom, $urandom};
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = cur_w[i];
            i++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = {4{32'hdeadbeef}};
        c1   = 0;
        seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (lit && t < 2 * DEPTH)
                chk($sformatf("lit_beat%0d", t), {rom_w, tf_out},
                    {(t < DEPTH) ? 2'd1 : 2'd2, lit_beat[t]});
            if (abort_beat > 0 && rom_w == 2'd1) begin
                c1++;
                if (c1 == abort_beat) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    chk("abort_rom_w", PW'(rom_w), '0);
                    chk("abort_busy",  PW'(busy),  '0);
                    rst_n = 1'b1;
                    return;
                end
            end
            if (done) begin
                if (lit) chk("done_cycle", PW'(t + 1), PW'(2 * DEPTH + 1));
                seen  = 1'b1;
                start = noise;
                @(negedge clk);
                start = 1'b0;
                break;
            end
            if (noise) start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
        if (!seen) chk("done_timeout", '0, PW'(1));
        else for (int s = 0; s < DEPTH; s++) chk($sformatf("rx_slot%0d", s), rx_mem[s], cur_w[s]);
        repeat (3) @(negedge clk);
    endtask

    task automatic rand_words();
        for (int s = 0; s < DEPTH; s++) cur_w[s] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic basic_words();
        cur_w[0] = 128'h0000000000000001_0000000000000001;
        cur_w[1] = 128'h0200000000000000_585bda2e086ebc26;
        cur_w[2] = 128'hfffffffefffc0001_00000007fff7fff8;
        cur_w[3] = 128'hfffff7ff00000801_7202dad8187e103f;
    endtask

    initial begin
        lit_beat[0] = 64'h0000000000000001;
        lit_beat[1] = 64'h0200000000000000;
        lit_beat[2] = 64'hfffffffefffc0001;
        lit_beat[3] = 64'hfffff7ff00000801;
        lit_beat[4] = 64'h0000000000000001;
        lit_beat[5] = 64'h585bda2e086ebc26;
        lit_beat[6] = 64'h00000007fff7fff8;
        lit_beat[7] = 64'h7202dad8187e103f;

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Basic back-to-back transfer with pinned beats and latency
        basic_words();
        run_xfer(0, 1'b1, 1'b0, 0);

        // Alternating in_valid: identical stream expected
        run_xfer(1, 1'b1, 1'b0, 0);

        // start noise while streaming and in DONE
        run_xfer(0, 1'b1, 1'b1, 0);
        repeat (12) @(negedge clk);

        // in_valid in IDLE with junk data is dropped
        in_valid = 1'b1;
        in_data  = {4{32'hdeaddead}};
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        rand_words();
        run_xfer(0, 1'b0, 1'b0, 0);

        // Reset during the third upper-half beat, then a clean transfer
        rand_words();
        run_xfer(0, 1'b0, 1'b0, 3);
        repeat (4) @(negedge clk);
        rand_words();
        run_xfer(2, 1'b0, 1'b0, 0);

        // Randomized transfers
        for (int n = 0; n < 25; n++) begin
            rand_words();
            run_xfer(2, 1'b0, 1'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global bound on run time
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_err);
        $fatal(1);
    end

endmodule

// File: doc/tw_horizontal_tx.md
Name: tw_horizontal_tx

Overview:
- Transmit end of the horizontal twiddle-factor load path.
- Collects DEPTH 128-bit twiddle words from an upstream source over a valid/ready handshake.
- Serializes the words into 64-bit beats with a 2-bit write code that the twiddle ROM's stage-0 buffer consumes: code 1 writes the upper halves, code 2 writes the lower halves, and the ROM's slot counter advances per beat.
- Sits between the twiddle generator/host loader and the TW_ROM stage-0 buffers.

Parameters:
- P_WIDTH, 128, full twiddle word width (two packed 64-bit factors).
- horizontal_DW, 64, beat width; must equal P_WIDTH/2.
- DEPTH, 4, words per transfer; must match the ROM stage-0 slot count; DEPTH >= 2, power of two.
- IDX_W, 2, log2(DEPTH).

Ports:
- CLK  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request to begin a transfer; sampled only in IDLE
- in_valid  in  1  upstream word valid
- in_data  in  P_WIDTH  upstream twiddle word, upper factor in [P_WIDTH-1:horizontal_DW]
- in_ready  out  1  high in LOAD only (registered-state decode)
- horizontal_tf_out  out  horizontal_DW  beat to the ROM's horizontal_tf_in
- ROM_w  out  2  0 = idle, 1 = upper-half write, 2 = lower-half write; 3 never driven
- busy  out  1  high in LOAD, SEND_HI, SEND_LO
- done  out  1  one-cycle pulse after the last beat

Behaviour:
- One clock (CLK). Reset is synchronous and active-low on rst_n. All state changes on the rising edge of CLK.
- Reset values: state = IDLE; horizontal_tf_out = 0; ROM_w = 0; done = 0; busy = 0; in_ready = 0; wr_idx = 0; rd_idx = 0. Buffer contents are not reset.
- rst_n low mid-transfer aborts the transfer. ROM_w is 0 on the first edge after rst_n is sampled low, which also returns the ROM slot counter to 0.
- FSM states: IDLE, LOAD, SEND_HI, SEND_LO, DONE.
- IDLE: start = 1 -> LOAD, with wr_idx = 0. Otherwise stay. in_valid is ignored.
- LOAD:
  - Each cycle with in_valid & in_ready, store in_data into buf[wr_idx] and increment wr_idx.
  - On the accept with wr_idx = DEPTH-1, go to SEND_HI.
  - On that same edge, register horizontal_tf_out = buf[0][P_WIDTH-1:horizontal_DW], ROM_w = 1, rd_idx = 1.
  - No timeout; the block waits indefinitely for in_valid.
- SEND_HI:
  - Each edge outputs buf[rd_idx] upper half with ROM_w = 1, then increments rd_idx.
  - After the beat for index DEPTH-1 is out, the next edge outputs buf[0] lower half with ROM_w = 2, sets rd_idx = 1 and goes to SEND_LO.
- SEND_LO: same as SEND_HI with lower halves [horizontal_DW-1:0] and ROM_w = 2. After index DEPTH-1, the next edge goes to DONE with ROM_w = 0 and done = 1.
- DONE: lasts one cycle, done = 1. The next edge goes to IDLE with done = 0. start is ignored in DONE.
- Beat stream:
  - Exactly 2*DEPTH contiguous cycles with ROM_w != 0: DEPTH cycles of code 1, then immediately DEPTH cycles of code 2.
  - No bubble is allowed inside the stream, because the ROM slot counter resets to 0 whenever ROM_w = 0.
  - The stream is always preceded and followed by at least one cycle of ROM_w = 0.
- Latency: from the edge accepting the last word to done high is 2*DEPTH+1 cycles.
- horizontal_tf_out holds its last value when ROM_w = 0; it is don't-care to the receiver.
- start while busy has no effect.
- An in_valid pulse outside LOAD is dropped and never stored.
- Indices are IDX_W bits wide and wrap naturally at DEPTH.

Decomposition:
- Shared package tw_pkg:
  - ROM_W_IDLE = 2'd0, ROM_W_HI = 2'd1, ROM_W_LO = 2'd2.
  - FSM state enum.
  - P_WIDTH and horizontal_DW defaults, shared with the TW_ROM blocks.
- One natural sub-module: tw_word_buf, a DEPTH x P_WIDTH register file with write port (we, waddr, wdata) and combinational read port selecting the half. The FSM and counters stay in the top.

Test Plan:
- Reset then idle: rst_n low 2 cycles, then 10 idle cycles -> ROM_w = 0, done = 0, busy = 0, in_ready = 0 throughout.
- Basic transfer, DEPTH = 4:
  - Words: W0 = 0000000000000001_0000000000000001, W1 = 0200000000000000_585bda2e086ebc26, W2 = fffffffefffc0001_00000007fff7fff8, W3 = fffff7ff00000801_7202dad8187e103f, sent back-to-back.
  - Expect beats (ROM_w = 1) 0000000000000001, 0200000000000000, fffffffefffc0001, fffff7ff00000801.
  - Then beats (ROM_w = 2) 0000000000000001, 585bda2e086ebc26, 00000007fff7fff8, 7202dad8187e103f.
  - done pulses on cycle 9 after the last accept.
- Throttled upstream: in_valid toggling 1/0 -> only valid cycles stored; the output stream is identical to the basic case and is 8 contiguous beats.
- Ignored inputs:
  - start asserted during SEND_HI and in DONE -> no restart, exactly one done pulse.
  - in_valid with data 0xDEAD... in IDLE -> not stored; next transfer carries only LOAD-phase words.
- Reset mid-stream: rst_n low during the 3rd code-1 beat -> ROM_w = 0 and busy = 0 from the next edge. A subsequent start and full transfer completes normally.
- Receiver co-simulation: drive TW_ROM6_1024_64 (ROM6_w <- ROM_w, horizontal_tf_in <- horizontal_tf_out) -> ROM stage-0 buffer holds W0..W3 at slots 0..3 after done.
